spi_slave_param: RTL and testbench



---
 rtl/spi_slave_param.sv | 230 +++++++++++++++++++++++
 tb/tb_spi_slave_param.sv | 438 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_slave_param.sv
`default_nettype none
// ============================================================================
// Module   : spi_slave_param
// Brief    : Oversampled SPI slave, any CPOL/CPHA, {cmd,payload} frames with
//            rd_data reply, underrun and framing-error reporting.
// Revision : 1.0 - initial release
// ============================================================================
module spi_slave_param #(
    parameter int DATA_W      = 8,
    parameter int CMD_W       = 2,
    parameter bit CPOL        = 1'b0,
    parameter bit CPHA        = 1'b0,
    parameter int SYNC_STAGES = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    sclk,
    input  logic                    ss_n,
    input  logic                    mosi,
    output logic                    miso,
    output logic                    miso_oe,
    output logic [CMD_W+DATA_W-1:0] rx_data,
    output logic                    rx_valid,
    input  logic [DATA_W-1:0]       tx_data,
    input  logic                    tx_valid,
    output logic                    tx_underrun,
    output logic                    frame_err
);

    localparam int c_FRAME_LEN = CMD_W + DATA_W;
    localparam int c_CNT_W     = $clog2(c_FRAME_LEN + DATA_W + 1);

    localparam logic [c_CNT_W-1:0] c_CNT_ONE   = c_CNT_W'(1);
    localparam logic [c_CNT_W-1:0] c_CNT_FRAME = c_CNT_W'(c_FRAME_LEN);
    localparam logic [c_CNT_W-1:0] c_CNT_LAST  = c_CNT_W'(c_FRAME_LEN + DATA_W - 1);

    localparam bit c_SAMPLE_RISE = (CPOL == CPHA);

    localparam logic [2:0] c_IDLE    = 3'd0;
    localparam logic [2:0] c_RX      = 3'd1;
    localparam logic [2:0] c_TX_WAIT = 3'd2;
    localparam logic [2:0] c_TX      = 3'd3;
    localparam logic [2:0] c_HOLD    = 3'd4;

    // ------------------------------------------------------------------------
    // Input synchronisers and edge detection
    // ------------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] r_sclk_sync;
    logic [SYNC_STAGES-1:0] r_ss_sync;
    logic [SYNC_STAGES-1:0] r_mosi_sync;
    logic                   r_sclk_d;
    logic                   r_ss_d;
    logic                   r_armed;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sclk_sync <= {SYNC_STAGES{CPOL}};
            r_ss_sync   <= '0;
            r_mosi_sync <= '0;
            r_sclk_d    <= CPOL;
            r_ss_d      <= 1'b0;
        end else begin
            r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], sclk};
            r_ss_sync   <= {r_ss_sync[SYNC_STAGES-2:0], ss_n};
            r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], mosi};
            r_sclk_d    <= r_sclk_sync[SYNC_STAGES-1];
            r_ss_d      <= r_ss_sync[SYNC_STAGES-1];
        end
    end

    logic w_sclk_s;
    logic w_ss_s;
    logic w_mosi_s;
    logic w_sclk_rise;
    logic w_sclk_fall;
    logic w_sample;
    logic w_launch;
    logic w_ss_fall;
    logic w_ss_rise;

    assign w_sclk_s    = r_sclk_sync[SYNC_STAGES-1];
    assign w_ss_s      = r_ss_sync[SYNC_STAGES-1];
    assign w_mosi_s    = r_mosi_sync[SYNC_STAGES-1];
    assign w_sclk_rise = w_sclk_s & ~r_sclk_d;
    assign w_sclk_fall = ~w_sclk_s & r_sclk_d;
    assign w_sample    = c_SAMPLE_RISE ? w_sclk_rise : w_sclk_fall;
    assign w_launch    = c_SAMPLE_RISE ? w_sclk_fall : w_sclk_rise;

    // ss_n chain resets low, so a fall is only seen after a genuine high:
    // a frame already running when reset is released is ignored.
    assign w_ss_fall = r_ss_d & ~w_ss_s;
    assign w_ss_rise = ~r_ss_d & w_ss_s;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_armed <= 1'b0;
        end else if (w_ss_s) begin
            r_armed <= 1'b1;
        end
    end

    assign miso_oe = r_armed & ~w_ss_s;

    // ------------------------------------------------------------------------
    // Frame FSM and datapath
    // ------------------------------------------------------------------------
    logic [2:0]             r_state;
    logic [c_CNT_W-1:0]     r_count;
    logic [c_FRAME_LEN-1:0] r_rx_sr;
    logic [c_FRAME_LEN-1:0] r_rx_data;
    logic [DATA_W-1:0]      r_tx_sr;
    logic                   r_tx_loaded;
    logic                   r_miso;
    logic                   r_rx_valid;
    logic                   r_underrun;
    logic                   r_frame_err;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= c_IDLE;
            r_count     <= '0;
            r_rx_sr     <= '0;
            r_rx_data   <= '0;
            r_tx_sr     <= '0;
            r_tx_loaded <= 1'b0;
            r_miso      <= 1'b0;
            r_rx_valid  <= 1'b0;
            r_underrun  <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            r_rx_valid  <= 1'b0;
            r_underrun  <= 1'b0;
            r_frame_err <= 1'b0;

            case (r_state)
                c_IDLE: begin
                    r_miso      <= 1'b0;
                    r_count     <= '0;
                    r_rx_sr     <= '0;
                    r_tx_loaded <= 1'b0;
                    if (w_ss_fall) begin
                        r_state <= c_RX;
                    end
                end

                c_RX: begin
                    if (r_count == c_CNT_FRAME) begin
                        r_rx_data   <= r_rx_sr;
                        r_rx_valid  <= 1'b1;
                        r_tx_loaded <= 1'b0;
                        if (w_ss_rise) begin
                            r_state <= c_IDLE;
                        end else if (r_rx_sr[c_FRAME_LEN-1 -: 2] == 2'b11) begin
                            r_state <= c_TX_WAIT;
                        end else begin
                            r_state <= c_HOLD;
                        end
                    end else if (w_ss_rise) begin
                        // A coincident sample edge is dropped with the frame.
                        r_frame_err <= (r_count != '0);
                        r_state     <= c_IDLE;
                    end else if (w_sample) begin
                        r_rx_sr <= {r_rx_sr[c_FRAME_LEN-2:0], w_mosi_s};
                        r_count <= r_count + c_CNT_ONE;
                    end
                end

                c_TX_WAIT: begin
                    if (w_ss_rise) begin
                        r_frame_err <= 1'b1;
                        r_state     <= c_IDLE;
                    end else if (w_launch) begin
                        if (r_tx_loaded) begin
                            r_miso  <= r_tx_sr[DATA_W-1];
                            r_tx_sr <= {r_tx_sr[DATA_W-2:0], 1'b0};
                        end else if (tx_valid) begin
                            r_miso  <= tx_data[DATA_W-1];
                            r_tx_sr <= {tx_data[DATA_W-2:0], 1'b0};
                        end else begin
                            r_miso     <= 1'b0;
                            r_tx_sr    <= '0;
                            r_underrun <= 1'b1;
                        end
                        r_tx_loaded <= 1'b1;
                        r_state     <= c_TX;
                    end else if (tx_valid && !r_tx_loaded) begin
                        r_tx_sr     <= tx_data;
                        r_tx_loaded <= 1'b1;
                    end
                end

                c_TX: begin
                    if (w_ss_rise) begin
                        r_frame_err <= 1'b1;
                        r_state     <= c_IDLE;
                    end else begin
                        if (w_launch) begin
                            r_miso  <= r_tx_sr[DATA_W-1];
                            r_tx_sr <= {r_tx_sr[DATA_W-2:0], 1'b0};
                        end
                        if (w_sample) begin
                            r_count <= r_count + c_CNT_ONE;
                            if (r_count == c_CNT_LAST) begin
                                r_state <= c_HOLD;
                            end
                        end
                    end
                end

                c_HOLD: begin
                    if (w_ss_rise) begin
                        r_state <= c_IDLE;
                    end
                end

                default: begin
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

    assign miso        = r_miso;
    assign rx_data     = r_rx_data;
    assign rx_valid    = r_rx_valid;
    assign tx_underrun = r_underrun;
    assign frame_err   = r_frame_err;

endmodule
`default_nettype wire

// File: tb/tb_spi_slave_param.sv
`default_nettype none
// Bench for spi_slave_param: four 8-bit mode instances plus a 16-bit payload
// instance share one SPI master; received frames are checked via a scoreboard.
module tb_spi_slave_param;

    localparam int H = 80;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        sclk_bus;
    logic        ss_bus;
    logic        mosi;
    logic [15:0] tx_data;
    logic        tx_valid;
    logic [2:0]  sel;
    logic        cur_cpol;
    logic        cur_cpha;
    logic [4:0]  cpol_v;
    logic [4:0]  cpha_v;
    logic [4:0]  sclk_v;
    logic [4:0]  ss_v;

    wire  [4:0]  miso_v;
    wire  [4:0]  oe_v;
    wire  [4:0]  rxv_v;
    wire  [4:0]  und_v;
    wire  [4:0]  fe_v;
    wire  [9:0]  rxd0, rxd1, rxd2, rxd3;
    wire  [17:0] rxd4;

    logic        obs_miso, obs_oe, obs_rxv, obs_und, obs_fe;
    logic [17:0] obs_rxd;

    int          errors = 0;
    int          checks = 0;
    int          rxv_cnt = 0;
    int          und_cnt = 0;
    int          fe_cnt = 0;
    int          bit_idx = 0;
    logic [17:0] exp_q[$];
    logic [17:0] exp_v;

    initial begin
        cpol_v = 5'b01100;
        cpha_v = 5'b01010;
    end

    always_comb begin
        sclk_v = cpol_v;
        ss_v   = 5'b11111;
        for (int k = 0; k < 5; k++) begin
            if (sel == 3'(k)) begin
                sclk_v[k] = sclk_bus;
                ss_v[k]   = ss_bus;
            end
        end
    end

    always_comb begin
        obs_miso = miso_v[sel];
        obs_oe   = oe_v[sel];
        obs_rxv  = rxv_v[sel];
        obs_und  = und_v[sel];
        obs_fe   = fe_v[sel];
        case (sel)
            3'd0:    obs_rxd = {8'h00, rxd0};
            3'd1:    obs_rxd = {8'h00, rxd1};
            3'd2:    obs_rxd = {8'h00, rxd2};
            3'd3:    obs_rxd = {8'h00, rxd3};
            default: obs_rxd = rxd4;
        endcase
    end

    spi_slave_param #(.DATA_W(8), .CMD_W(2), .CPOL(1'b0), .CPHA(1'b0), .SYNC_STAGES(2)) u_m0 (
        .clk(clk), .rst_n(rst_n), .sclk(sclk_v[0]), .ss_n(ss_v[0]), .mosi(mosi),
        .miso(miso_v[0]), .miso_oe(oe_v[0]), .rx_data(rxd0), .rx_valid(rxv_v[0]),
        .tx_data(tx_data[7:0]), .tx_valid(tx_valid), .tx_underrun(und_v[0]), .frame_err(fe_v[0]));

    spi_slave_param #(.DATA_W(8), .CMD_W(2), .CPOL(1'b0), .CPHA(1'b1), .SYNC_STAGES(2)) u_m1 (
        .clk(clk), .rst_n(rst_n), .sclk(sclk_v[1]), .ss_n(ss_v[1]), .mosi(mosi),
        .miso(miso_v[1]), .miso_oe(oe_v[1]), .rx_data(rxd1), .rx_valid(rxv_v[1]),
        .tx_data(tx_data[7:0]), .tx_valid(tx_valid), .tx_underrun(und_v[1]), .frame_err(fe_v[1]));

    spi_slave_param #(.DATA_W(8), .CMD_W(2), .CPOL(1'b1), .CPHA(1'b0), .SYNC_STAGES(2)) u_m2 (
        .clk(clk), .rst_n(rst_n), .sclk(sclk_v[2]), .ss_n(ss_v[2]), .mosi(mosi),
        .miso(miso_v[2]), .miso_oe(oe_v[2]), .rx_data(rxd2), .rx_valid(rxv_v[2]),
        .tx_data(tx_data[7:0]), .tx_valid(tx_valid), .tx_underrun(und_v[2]), .frame_err(fe_v[2]));

    spi_slave_param #(.DATA_W(8), .CMD_W(2), .CPOL(1'b1), .CPHA(1'b1), .SYNC_STAGES(2)) u_m3 (
        .clk(clk), .rst_n(rst_n), .sclk(sclk_v[3]), .ss_n(ss_v[3]), .mosi(mosi),
        .miso(miso_v[3]), .miso_oe(oe_v[3]), .rx_data(rxd3), .rx_valid(rxv_v[3]),
        .tx_data(tx_data[7:0]), .tx_valid(tx_valid), .tx_underrun(und_v[3]), .frame_err(fe_v[3]));

    spi_slave_param #(.DATA_W(16), .CMD_W(2), .CPOL(1'b0), .CPHA(1'b0), .SYNC_STAGES(2)) u_w16 (
        .clk(clk), .rst_n(rst_n), .sclk(sclk_v[4]), .ss_n(ss_v[4]), .mosi(mosi),
        .miso(miso_v[4]), .miso_oe(oe_v[4]), .rx_data(rxd4), .rx_valid(rxv_v[4]),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_underrun(und_v[4]), .frame_err(fe_v[4]));

    // Scoreboard: every rx_valid pulse must match the oldest expected frame.
    always @(negedge clk) begin
        if (rst_n) begin
            if (obs_rxv) begin
                rxv_cnt++;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL rx_frame: unexpected rx_valid with rx_data=%h, required no pulse", obs_rxd);
                end else begin
                    exp_v = exp_q.pop_front();
                    if (obs_rxd !== exp_v) begin
                        errors++;
                        $display("FAIL rx_frame: got %h, required %h", obs_rxd, exp_v);
                    end
                end
            end
            if (obs_und) und_cnt++;
            if (obs_fe)  fe_cnt++;
        end
    end

    task automatic select_dut(input int k);
        sel      = 3'(k);
        cur_cpol = cpol_v[k];
        cur_cpha = cpha_v[k];
        sclk_bus = cur_cpol;
        ss_bus   = 1'b1;
        mosi     = 1'b0;
        #(4*H);
    endtask

    task automatic ss_begin();
        bit_idx = 0;
        ss_bus  = 1'b0;
        #(H);
    endtask

    task automatic ss_end();
        #(H);
        ss_bus = 1'b1;
        #(2*H);
    endtask

    task automatic spi_bit(input logic b, output logic m);
        if (!cur_cpha) begin
            mosi = b;
            #(H);
            m = obs_miso;
            sclk_bus = ~cur_cpol;
            bit_idx++;
            #(H);
            sclk_bus = cur_cpol;
        end else begin
            sclk_bus = ~cur_cpol;
            mosi = b;
            #(H);
            m = obs_miso;
            sclk_bus = cur_cpol;
            bit_idx++;
            #(H);
        end
    endtask

    task automatic spi_frame(input int n, input logic [31:0] frame, input int total,
                             output logic [31:0] reply);
        logic m;
        reply = '0;
        ss_begin();
        for (int i = 0; i < total; i++) begin
            spi_bit((i < n) ? frame[n-1-i] : 1'b0, m);
            reply = {reply[30:0], m};
        end
        ss_end();
    endtask

    task automatic feed_tx(input logic [15:0] d, output int seen_idx);
        logic seen;
        seen = 1'b0;
        seen_idx = -1;
        for (int k = 0; k < 5000 && !seen; k++) begin
            @(negedge clk);
            if (obs_rxv) begin
                seen = 1'b1;
                seen_idx = bit_idx;
            end
        end
        if (seen) begin
            repeat (2) @(negedge clk);
            tx_data  = d;
            tx_valid = 1'b1;
            @(negedge clk);
            tx_valid = 1'b0;
        end
    endtask

    task automatic test_reset();
        rst_n    = 1'b0;
        tx_data  = '0;
        tx_valid = 1'b0;
        select_dut(0);
        checks++;
        if ({miso_v, oe_v, rxv_v, und_v, fe_v} !== 25'd0) begin
            errors++;
            $display("FAIL reset_flags: got %h, required 0", {miso_v, oe_v, rxv_v, und_v, fe_v});
        end
        checks++;
        if ({rxd0, rxd1, rxd2, rxd3, rxd4} !== 58'd0) begin
            errors++;
            $display("FAIL reset_rx_data: got %h, required 0", {rxd0, rxd1, rxd2, rxd3, rxd4});
        end
        @(negedge clk);
        rst_n = 1'b1;
        #(4*H);
        checks++;
        if (oe_v !== 5'b00000) begin
            errors++;
            $display("FAIL idle_miso_oe: got %b, required 00000", oe_v);
        end
    endtask

    task automatic test_mode0_write();
        int r0 = rxv_cnt;
        int u0 = und_cnt;
        int f0 = fe_cnt;
        logic [31:0] reply;
        select_dut(0);
        exp_q.push_back(18'h001A5);
        spi_frame(10, 32'h1A5, 10, reply);
        checks++;
        if (rxv_cnt - r0 !== 1) begin
            errors++;
            $display("FAIL m0_rx_pulses: got %0d, required 1", rxv_cnt - r0);
        end
        checks++;
        if (reply[9:0] !== 10'd0) begin
            errors++;
            $display("FAIL m0_miso_idle: got %h, required 0", reply[9:0]);
        end
        checks++;
        if ({und_cnt - u0, fe_cnt - f0} !== {32'd0, 32'd0}) begin
            errors++;
            $display("FAIL m0_no_errors: got und=%0d fe=%0d, required 0 0", und_cnt - u0, fe_cnt - f0);
        end
        checks++;
        if (obs_rxd !== 18'h001A5) begin
            errors++;
            $display("FAIL m0_rx_hold: got %h, required 001a5", obs_rxd);
        end
    endtask

    task automatic test_mode3_read();
        int r0 = rxv_cnt;
        int u0 = und_cnt;
        int idx;
        logic [31:0] reply;
        select_dut(3);
        exp_q.push_back(18'h00300);
        fork
            spi_frame(10, 32'h300, 18, reply);
            feed_tx(16'h00A5, idx);
        join
        checks++;
        if (reply[7:0] !== 8'hA5) begin
            errors++;
            $display("FAIL m3_reply: got %h, required a5", reply[7:0]);
        end
        checks++;
        if (und_cnt - u0 !== 0 || rxv_cnt - r0 !== 1) begin
            errors++;
            $display("FAIL m3_pulses: got und=%0d rxv=%0d, required 0 1", und_cnt - u0, rxv_cnt - r0);
        end
    endtask

    task automatic test_underrun();
        logic [31:0] reply;
        for (int k = 1; k <= 2; k++) begin
            int u0 = und_cnt;
            select_dut(k);
            exp_q.push_back(18'h00300);
            spi_frame(10, 32'h300, 18, reply);
            checks++;
            if (und_cnt - u0 !== 1) begin
                errors++;
                $display("FAIL underrun_pulse_m%0d: got %0d, required 1", k, und_cnt - u0);
            end
            checks++;
            if (reply[7:0] !== 8'h00) begin
                errors++;
                $display("FAIL underrun_reply_m%0d: got %h, required 00", k, reply[7:0]);
            end
            checks++;
            if (obs_rxd !== 18'h00300) begin
                errors++;
                $display("FAIL underrun_rx_m%0d: got %h, required 00300", k, obs_rxd);
            end
        end
    endtask

    task automatic test_abort();
        int r0 = rxv_cnt;
        int f0 = fe_cnt;
        logic m;
        logic [31:0] reply;
        select_dut(0);
        ss_begin();
        for (int i = 0; i < 6; i++) spi_bit(i[0], m);
        ss_end();
        checks++;
        if (fe_cnt - f0 !== 1 || rxv_cnt - r0 !== 0) begin
            errors++;
            $display("FAIL abort_pulses: got fe=%0d rxv=%0d, required 1 0", fe_cnt - f0, rxv_cnt - r0);
        end
        checks++;
        if (obs_rxd !== 18'h001A5) begin
            errors++;
            $display("FAIL abort_rx_hold: got %h, required 001a5", obs_rxd);
        end
        exp_q.push_back(18'h002C3);
        spi_frame(10, 32'h2C3, 10, reply);
        checks++;
        if (obs_rxd !== 18'h002C3 || fe_cnt - f0 !== 1) begin
            errors++;
            $display("FAIL abort_recover: got %h fe=%0d, required 002c3 1", obs_rxd, fe_cnt - f0);
        end
    endtask

    task automatic test_back_to_back();
        int r0 = rxv_cnt;
        int f0 = fe_cnt;
        logic [31:0] reply;
        logic [9:0]  frames [3];
        frames[0] = 10'h012;
        frames[1] = 10'h1FF;
        frames[2] = 10'h234;
        select_dut(0);
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back({8'h00, frames[i]});
            spi_frame(10, {22'd0, frames[i]}, 10, reply);
        end
        checks++;
        if (rxv_cnt - r0 !== 3 || exp_q.size() !== 0) begin
            errors++;
            $display("FAIL b2b_count: got rxv=%0d pending=%0d, required 3 0", rxv_cnt - r0, exp_q.size());
        end
        checks++;
        if (obs_rxd !== 18'h00234 || fe_cnt - f0 !== 0) begin
            errors++;
            $display("FAIL b2b_last: got %h fe=%0d, required 00234 0", obs_rxd, fe_cnt - f0);
        end
    endtask

    task automatic test_reset_mid_frame();
        int r0;
        int f0;
        logic m;
        logic [31:0] reply;
        select_dut(0);
        ss_begin();
        for (int i = 0; i < 4; i++) spi_bit(1'b1, m);
        rst_n = 1'b0;
        #1;
        checks++;
        if ({obs_miso, obs_oe, obs_rxv, obs_und, obs_fe, obs_rxd} !== 23'd0) begin
            errors++;
            $display("FAIL reset_mid_rx: got %h, required 0",
                     {obs_miso, obs_oe, obs_rxv, obs_und, obs_fe, obs_rxd});
        end
        #9;
        @(negedge clk);
        rst_n = 1'b1;
        r0 = rxv_cnt;
        f0 = fe_cnt;
        for (int i = 0; i < 6; i++) spi_bit(1'b1, m);
        ss_end();
        exp_q.push_back(18'h00155);
        spi_frame(10, 32'h155, 10, reply);
        checks++;
        if (obs_rxd !== 18'h00155 || fe_cnt - f0 !== 0 || rxv_cnt - r0 !== 1) begin
            errors++;
            $display("FAIL reset_recover: got %h fe=%0d rxv=%0d, required 00155 0 1",
                     obs_rxd, fe_cnt - f0, rxv_cnt - r0);
        end
    endtask

    task automatic test_wide();
        int u0 = und_cnt;
        int idx;
        logic [31:0] reply;
        select_dut(4);
        exp_q.push_back(18'h30000);
        fork
            spi_frame(18, 32'h30000, 34, reply);
            feed_tx(16'hBEEF, idx);
        join
        checks++;
        if (idx !== 18) begin
            errors++;
            $display("FAIL wide_rx_latency: got rx_valid after bit %0d, required 18", idx);
        end
        checks++;
        if (reply[15:0] !== 16'hBEEF || und_cnt - u0 !== 0) begin
            errors++;
            $display("FAIL wide_reply: got %h und=%0d, required beef 0", reply[15:0], und_cnt - u0);
        end
        checks++;
        if (obs_rxd !== 18'h30000) begin
            errors++;
            $display("FAIL wide_rx_hold: got %h, required 30000", obs_rxd);
        end
    endtask

    initial begin
        test_reset();
        test_mode0_write();
        test_mode3_read();
        test_underrun();
        test_abort();
        test_back_to_back();
        test_reset_mid_frame();
        test_wide();
        checks++;
        if (exp_q.size() !== 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending frames, required 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #(500_000);
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
